ui_input_conditioner: RTL and testbench

- Input-conditioning stage that sits directly upstream of the top-level gate logic.
- Takes the 8 raw dedicated input pins and, per bit, applies a 2-flop synchronizer, a counter-based debouncer and an edge detector.
- The gate logic consumes clean_out in place of the raw pins; rise_pulse, fall_pulse and changed are available to later sequential logic.

---
 rtl/ui_input_conditioner_if.sv | 22 ++
 rtl/ui_input_conditioner.sv | 86 ++++++++
 tb/tb_ui_input_conditioner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ui_input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw pins and enable in,
// debounced levels and edge strobes out.
interface ui_input_conditioner_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic             changed;

  modport master (
    output ena, raw_in,
    input  clean_out, rise_pulse, fall_pulse, changed
  );

  modport slave (
    input  ena, raw_in,
    output clean_out, rise_pulse, fall_pulse, changed
  );
endinterface

// File: rtl/ui_input_conditioner.sv
// Per-bit input conditioning: 2-flop synchronizer, counter debouncer and
// registered edge strobes. Every output is a flop, so no raw_in path reaches
// an output combinationally.
module ui_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  ui_input_conditioner_if.slave bus
);

  // Counter terminal value; the counter never goes past it, so it cannot wrap.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_clean;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]            r_rise;
  logic [WIDTH-1:0]            r_fall;
  logic                        r_changed;

  logic [WIDTH-1:0]            w_clean_nxt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            w_rise_nxt;
  logic [WIDTH-1:0]            w_fall_nxt;

  // Synchronizer chain runs on every edge, independent of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce decision per bit; with ena low everything holds and strobes stay 0.
  always_comb begin
    w_clean_nxt = r_clean;
    w_cnt_nxt   = r_cnt;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    if (bus.ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_clean[i]) begin
          // Any return to the settled level discards progress, so bounces never accumulate.
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_TERM) begin
          w_clean_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]   = '0;
          w_rise_nxt[i]  = r_sync2[i];
          w_fall_nxt[i]  = ~r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and strobes update together, so a strobe lines up with its clean_out change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean   <= '0;
      r_cnt     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_clean   <= w_clean_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign bus.clean_out  = r_clean;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.changed    = r_changed;

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed bench for ui_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before any new drive, so a sample taken after rising edge k reflects edge k.
module tb_ui_input_conditioner;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  ui_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

  ui_input_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] acc;
    int               n_rise;
    n_chk  = 0;
    n_pass = 0;

    // reset state
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.raw_in = 8'h00;
    tick();
    tick();
    chk("rst_clean",   32'(bus.clean_out),  32'h0);
    chk("rst_rise",    32'(bus.rise_pulse), 32'h0);
    chk("rst_fall",    32'(bus.fall_pulse), 32'h0);
    chk("rst_changed", 32'(bus.changed),    32'h0);
    rst_n = 1'b1;

    // quiet input for 20 cycles: nothing moves
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      acc = acc | bus.clean_out | bus.rise_pulse | bus.fall_pulse | {7'b0, bus.changed};
    end
    chk("quiet_any", 32'(acc), 32'h0);

    // single rising bit: flips after edge 5, strobe for exactly one cycle
    bus.raw_in = 8'h01;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk($sformatf("rise1_clean_e%0d", k),   32'(bus.clean_out),  (k >= 5) ? 32'h01 : 32'h00);
      chk($sformatf("rise1_pulse_e%0d", k),   32'(bus.rise_pulse), (k == 5) ? 32'h01 : 32'h00);
      chk($sformatf("rise1_changed_e%0d", k), 32'(bus.changed),    (k == 5) ? 32'h1  : 32'h0);
    end

    // bounce on bit 3: high at edges 0-2, low at 3, high from 4; counter reaches 3 then clears
    n_rise = 0;
    for (int k = 0; k <= 11; k++) begin
      if (k <= 2 || k >= 4) bus.raw_in = 8'h09;
      else                  bus.raw_in = 8'h01;
      tick();
      if (bus.rise_pulse[3]) n_rise++;
      chk($sformatf("bounce_clean_e%0d", k), 32'(bus.clean_out),  (k >= 9) ? 32'h09 : 32'h01);
      chk($sformatf("bounce_rise_e%0d", k),  32'(bus.rise_pulse), (k == 9) ? 32'h08 : 32'h00);
    end
    chk("bounce_rise_count", 32'(n_rise), 32'd1);

    // all ones, then 5A with several bits falling together
    bus.raw_in = 8'hFF;
    repeat (8) tick();
    chk("ff_clean", 32'(bus.clean_out), 32'hFF);
    bus.raw_in = 8'h5A;
    repeat (5) tick();
    chk("5a_clean_e4", 32'(bus.clean_out), 32'hFF);
    tick();
    chk("5a_clean",   32'(bus.clean_out),  32'h5A);
    chk("5a_fall",    32'(bus.fall_pulse), 32'hA5);
    chk("5a_rise",    32'(bus.rise_pulse), 32'h00);
    chk("5a_changed", 32'(bus.changed),    32'h1);
    tick();
    chk("5a_fall_after", 32'(bus.fall_pulse), 32'h00);
    chk("5a_chg_after",  32'(bus.changed),    32'h0);

    // ena drop after two counted edges: resumes from held count
    bus.raw_in = 8'h5B;
    repeat (4) tick();
    bus.ena = 1'b0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc = acc | bus.rise_pulse | bus.fall_pulse | {7'b0, bus.changed};
    end
    chk("ena_low_pulses", 32'(acc), 32'h0);
    chk("ena_low_clean",  32'(bus.clean_out), 32'h5A);
    bus.ena = 1'b1;
    tick();
    chk("ena_resume1_clean", 32'(bus.clean_out), 32'h5A);
    tick();
    chk("ena_resume2_clean", 32'(bus.clean_out),  32'h5B);
    chk("ena_resume2_rise",  32'(bus.rise_pulse), 32'h01);

    // async reset mid-count with clean_out at 0F
    bus.raw_in = 8'h0F;
    repeat (8) tick();
    chk("pre_rst_clean", 32'(bus.clean_out), 32'h0F);
    bus.raw_in = 8'h00;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clean",   32'(bus.clean_out),  32'h0);
    chk("arst_rise",    32'(bus.rise_pulse), 32'h0);
    chk("arst_fall",    32'(bus.fall_pulse), 32'h0);
    chk("arst_changed", 32'(bus.changed),    32'h0);
    bus.raw_in = 8'h0F;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_clean_e4", 32'(bus.clean_out), 32'h00);
    tick();
    chk("post_rst_clean_e5", 32'(bus.clean_out),  32'h0F);
    chk("post_rst_rise_e5",  32'(bus.rise_pulse), 32'h0F);
    tick();
    chk("post_rst_rise_e6",  32'(bus.rise_pulse), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
